// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the line-granular host memory controller.
package mem_ctrl_pkg;

  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT} state_e;

  localparam int ERR_BUSY    = 0;
  localparam int ERR_RANGE   = 1;
  localparam int ERR_UNSOL   = 2;
  localparam int ERR_TIMEOUT = 3;

  localparam int LINE_BYTES = 64;
  localparam int LINE_OFF   = $clog2(LINE_BYTES);
  localparam int LINE_BITS  = LINE_BYTES * 8;

endpackage

// File: rtl/mem_ctrl_mmio_regs.sv
// Host-programmed buffer base (line address) and its valid flag.
module mem_ctrl_mmio_regs
  import mem_ctrl_pkg::*;
#(
  parameter int          HOST_AW       = 42,
  parameter logic [15:0] MMIO_BASE_OFF = 16'h0020
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mmio_wr_valid,
  input  logic [15:0]        mmio_addr,
  input  logic [63:0]        mmio_wr_data,
  input  logic               busy,
  output logic [HOST_AW-1:0] base_line,
  output logic               buffer_addr_valid
);

  logic [HOST_AW-1:0] base_d, base_q;
  logic               valid_d, valid_q;
  logic               unused_mmio_bits;

  // Byte address is line aligned; only the line-index bits are kept.
  assign unused_mmio_bits = ^{mmio_wr_data[63:HOST_AW+LINE_OFF], mmio_wr_data[LINE_OFF-1:0]};

  always_comb begin
    base_d  = base_q;
    valid_d = valid_q;
    // Moving the base under an in-flight transaction would corrupt its address.
    if (mmio_wr_valid && (mmio_addr == MMIO_BASE_OFF) && !busy) begin
      base_d  = mmio_wr_data[HOST_AW+LINE_OFF-1:LINE_OFF];
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      base_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      base_q  <= base_d;
      valid_q <= valid_d;
    end
  end

  assign base_line         = base_q;
  assign buffer_addr_valid = valid_q;

endmodule

// File: rtl/mem_ctrl.sv
// Single-outstanding line read/write engine between the control unit and the
// host shared buffer, with range/busy checking and a response timeout.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int          HOST_AW       = 42,
  parameter logic [31:0] BUF_LINES     = 32'h0010_0000,
  parameter int          TIMEOUT       = 4096,
  parameter logic [15:0] MMIO_BASE_OFF = 16'h0020
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mmio_wr_valid,
  input  logic [15:0]          mmio_addr,
  input  logic [63:0]          mmio_wr_data,
  output logic                 buffer_addr_valid,
  input  logic [31:0]          address,
  input  logic                 read_request_valid,
  input  logic                 write_request_valid,
  input  logic [LINE_BITS-1:0] write_data,
  output logic                 data_valid,
  output logic [LINE_BITS-1:0] read_data,
  output logic                 write_done,
  output logic                 busy,
  output logic                 rd_req_valid,
  input  logic                 rd_req_ready,
  output logic [HOST_AW-1:0]   rd_req_addr,
  input  logic                 rd_rsp_valid,
  input  logic [LINE_BITS-1:0] rd_rsp_data,
  output logic                 wr_req_valid,
  input  logic                 wr_req_ready,
  output logic [HOST_AW-1:0]   wr_req_addr,
  output logic [LINE_BITS-1:0] wr_req_data,
  input  logic                 wr_rsp_valid,
  output logic [3:0]           err_flags
);

  localparam int CNT_W = $clog2(TIMEOUT) + 1;

  state_e               state_d, state_q;
  logic [CNT_W-1:0]     cnt_d, cnt_q;
  logic [HOST_AW-1:0]   phys_d, phys_q;
  logic [LINE_BITS-1:0] wdata_d, wdata_q;
  logic [LINE_BITS-1:0] rdata_d, rdata_q;
  logic                 dv_d, dv_q;
  logic                 wd_d, wd_q;
  logic [3:0]           err_d, err_q;
  logic [HOST_AW-1:0]   base_line;
  logic                 base_valid;
  logic                 cnt_expired;

  mem_ctrl_mmio_regs #(
    .HOST_AW       (HOST_AW),
    .MMIO_BASE_OFF (MMIO_BASE_OFF)
  ) u_regs (
    .clk               (clk),
    .rst               (rst),
    .mmio_wr_valid     (mmio_wr_valid),
    .mmio_addr         (mmio_addr),
    .mmio_wr_data      (mmio_wr_data),
    .busy              (busy),
    .base_line         (base_line),
    .buffer_addr_valid (base_valid)
  );

  assign cnt_expired = (cnt_q == CNT_W'(TIMEOUT - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    phys_d  = phys_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    dv_d    = 1'b0;
    wd_d    = 1'b0;
    err_d   = err_q;

    // Range error masks the busy error when both apply.
    if (read_request_valid || write_request_valid) begin
      if (address >= BUF_LINES) begin
        err_d[ERR_RANGE] = 1'b1;
      end else if ((state_q != IDLE) || !base_valid) begin
        err_d[ERR_BUSY] = 1'b1;
      end else begin
        phys_d = base_line + HOST_AW'(address);
        if (write_request_valid) begin
          state_d = WR_REQ;
          wdata_d = write_data;
          if (read_request_valid) err_d[ERR_BUSY] = 1'b1;
        end else begin
          state_d = RD_REQ;
        end
      end
    end

    case (state_q)
      RD_REQ: if (rd_req_ready) begin
        state_d = RD_WAIT;
        cnt_d   = '0;
      end
      WR_REQ: if (wr_req_ready) begin
        state_d = WR_WAIT;
        cnt_d   = '0;
      end
      RD_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (rd_rsp_valid) begin
          state_d = IDLE;
          dv_d    = 1'b1;
          rdata_d = rd_rsp_data;
        end else if (cnt_expired) begin
          // Zero-data completion keeps the client from waiting forever.
          state_d            = IDLE;
          dv_d               = 1'b1;
          rdata_d            = '0;
          err_d[ERR_TIMEOUT] = 1'b1;
        end
      end
      WR_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (wr_rsp_valid) begin
          state_d = IDLE;
          wd_d    = 1'b1;
        end else if (cnt_expired) begin
          state_d            = IDLE;
          wd_d               = 1'b1;
          err_d[ERR_TIMEOUT] = 1'b1;
        end
      end
      default: ;
    endcase

    if (rd_rsp_valid && (state_q != RD_WAIT)) err_d[ERR_UNSOL] = 1'b1;
    if (wr_rsp_valid && (state_q != WR_WAIT)) err_d[ERR_UNSOL] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      phys_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      dv_q    <= 1'b0;
      wd_q    <= 1'b0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      phys_q  <= phys_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      dv_q    <= dv_d;
      wd_q    <= wd_d;
      err_q   <= err_d;
    end
  end

  assign buffer_addr_valid = base_valid;
  assign busy              = (state_q != IDLE);
  assign rd_req_valid      = (state_q == RD_REQ);
  assign rd_req_addr       = phys_q;
  assign wr_req_valid      = (state_q == WR_REQ);
  assign wr_req_addr       = phys_q;
  assign wr_req_data       = wdata_q;
  assign data_valid        = dv_q;
  assign read_data         = rdata_q;
  assign write_done        = wd_q;
  assign err_flags         = err_q;

endmodule
